// File: rtl/max_pool_drain.sv
// max_pool_drain: reduces each 4-beat 2x2 window of the read-data stream to
// its signed maximum and writes it densely to the pooled buffer at base+idx.
module max_pool_drain #(
  parameter int MATRIX_SIZE = 24,
  parameter int ADD_SIZE    = 20,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADD_SIZE-1:0]          base_add_in,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         data_valid,
  output logic [ADD_SIZE-1:0]          wr_add,
  output logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         wr_en,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned NUM_WIN = (MATRIX_SIZE - 1) * (MATRIX_SIZE - 1);
  localparam int unsigned IDX_W   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WIN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_e;

  state_e                         state_q, state_d;
  logic [1:0]                     cnt_q, cnt_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic signed [DATA_WIDTH-1:0]   max_q, max_d;
  logic [ADD_SIZE-1:0]            base_q, base_d;
  logic [ADD_SIZE-1:0]            wr_add_q, wr_add_d;
  logic signed [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                           wr_en_q, wr_en_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic signed [DATA_WIDTH-1:0]   beat_max;

  // Running maximum including the current beat; the first beat of a window
  // replaces the max outright, which is how the max restarts per window.
  always_comb begin
    beat_max = max_q;
    if ((cnt_q == 2'd0) || (data_in > max_q)) begin
      beat_max = data_in;
    end
  end

  // Next-state and output logic for the drain FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    max_d     = max_q;
    base_d    = base_q;
    wr_add_d  = wr_add_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = done_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          base_d  = base_add_in;
          cnt_d   = '0;
          idx_d   = '0;
          max_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (data_valid) begin
          max_d = beat_max;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_data_d = beat_max;
            wr_add_d  = base_q + ADD_SIZE'(idx_q);
            idx_d     = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_DONE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      max_q     <= '0;
      base_q    <= '0;
      wr_add_q  <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      max_q     <= max_d;
      base_q    <= base_d;
      wr_add_q  <= wr_add_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign wr_add  = wr_add_q;
  assign wr_data = wr_data_q;
  assign wr_en   = wr_en_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_max_pool_drain.sv
// Bench for max_pool_drain with a window-level reference model.
module tb_max_pool_drain;

  localparam int N  = 3;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int TOTAL_BEATS = (N - 1) * (N - 1) * 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [AW-1:0]        base_add_in;
  logic signed [DW-1:0] data_in;
  logic                 data_valid;
  logic [AW-1:0]        wr_add;
  logic [DW-1:0]        wr_data;
  logic                 wr_en;
  logic                 busy;
  logic                 done;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: pass activity, done flag, base and beats of the
  // current window.
  bit            m_in_pass = 1'b0;
  bit            m_done = 1'b0;
  int            m_beats = 0;
  logic [AW-1:0] m_base = '0;
  int            m_win[$];

  max_pool_drain #(
    .MATRIX_SIZE(N),
    .ADD_SIZE(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .base_add_in(base_add_in),
    .data_in(data_in),
    .data_valid(data_valid),
    .wr_add(wr_add),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, then check outputs.
  task automatic step(input bit st, input logic [AW-1:0] b, input bit dv, input int d);
    bit            exp_wr = 1'b0;
    logic [AW-1:0] exp_a = '0;
    int            exp_m = 0;
    logic [DW-1:0] exp_d;
    start = st;
    base_add_in = b;
    data_valid = dv;
    data_in = DW'(d);
    if (!m_in_pass && st) begin
      m_in_pass = 1'b1;
      m_done = 1'b0;
      m_beats = 0;
      m_base = b;
      m_win.delete();
    end else if (m_in_pass && dv) begin
      m_win.push_back(d);
      m_beats++;
      if (m_win.size() == 4) begin
        exp_wr = 1'b1;
        exp_m = m_win[0];
        foreach (m_win[i]) if (m_win[i] > exp_m) exp_m = m_win[i];
        exp_a = m_base + AW'(m_beats / 4 - 1);
        m_win.delete();
        if (m_beats == TOTAL_BEATS) begin
          m_in_pass = 1'b0;
          m_done = 1'b1;
        end
      end
    end
    exp_d = DW'(exp_m);
    @(posedge clk);
    #1;
    chk("wr_en", 32'(wr_en), 32'(exp_wr));
    if (exp_wr) begin
      chk("wr_add", 32'(wr_add), 32'(exp_a));
      chk("wr_data", 32'(wr_data), 32'(exp_d));
    end
    chk("busy", 32'(busy), 32'(m_in_pass));
    chk("done", 32'(done), 32'(m_done));
    start = 1'b0;
    data_valid = 1'b0;
  endtask

  // Reset across one edge with live-looking inputs; everything must clear.
  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    data_valid = 1'b1;
    data_in = DW'($urandom);
    @(posedge clk);
    #1;
    m_in_pass = 1'b0;
    m_done = 1'b0;
    m_win.delete();
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_add", 32'(wr_add), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    data_valid = 1'b0;
  endtask

  task automatic run_pass(input logic [AW-1:0] b, input int d[16], input bit gaps,
                          input bit mid_start, input bit start_dv);
    step(1'b1, b, start_dv, 1234);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        repeat ($urandom_range(1, 3)) step(1'b0, '0, 1'b0, int'($urandom_range(0, 99)));
      end
      if (mid_start && i == 5) step(1'b1, ~b, 1'b0, 0);
      step(1'b0, '0, 1'b1, d[i]);
    end
    step(1'b0, '0, 1'b0, 0);
    step(1'b0, '0, 1'b0, 0);
  endtask

  int t1[16] = '{1, 5, 3, 2, -4, -1, -7, -2, 9, 9, 0, 9, 0, 0, 0, 0};
  int t3[16];
  int tr[16];

  initial begin
    logic signed [DW-1:0] r;
    reset = 1'b0;
    start = 1'b0;
    base_add_in = '0;
    data_in = '0;
    data_valid = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Data before any start is ignored.
    step(1'b0, '0, 1'b1, 7);
    step(1'b0, '0, 1'b1, 8);

    // Continuous pass.
    run_pass(20'h00100, t1, 1'b0, 1'b0, 1'b0);
    // Done holds; data after done ignored.
    step(1'b0, '0, 1'b1, 3);
    step(1'b0, 20'h00555, 1'b1, 4);

    // Start from DONE, gapped stream, start during busy ignored.
    run_pass(20'h00100, t1, 1'b1, 1'b1, 1'b0);

    // Signed extremes followed by random words.
    t3[0] = -32768; t3[1] = -32768; t3[2] = -32768; t3[3] = -32767;
    t3[4] = 32767;  t3[5] = -1;     t3[6] = 0;      t3[7] = 1;
    for (int i = 8; i < 16; i++) begin
      r = DW'($urandom);
      t3[i] = int'(r);
    end
    run_pass(20'h00040, t3, 1'b0, 1'b0, 1'b0);

    // Reset mid-window 2 aborts with no write.
    step(1'b1, 20'h00300, 1'b0, 0);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 100 + i);
    do_reset();
    step(1'b0, '0, 1'b1, 5);
    // Start with data in the same cycle: the data is dropped.
    run_pass(20'h00200, t1, 1'b0, 1'b0, 1'b1);

    // Address wrap with random data and gaps.
    for (int i = 0; i < 16; i++) begin
      r = DW'($urandom);
      tr[i] = int'(r);
    end
    run_pass(20'hFFFFE, tr, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
